spart_driver: RTL and testbench

- Bus master that sequences the SPART through its processor-side interface (iocs/iorw/ioaddr/databus, rda/tbr).
- After reset or any baud-select change, it programs the 16-bit baud divisor (low byte, then high byte).
- It then runs an echo loop: every received byte is read into a small FIFO and written back to the transmitter when tbr allows.
- Sits beside the spart in the top level and replaces a processor for bring-up and loopback.

---
 rtl/spart_pkg.sv | 20 ++
 rtl/spart_driver_if.sv | 11 +
 rtl/spart_fifo.sv | 48 ++++
 rtl/spart_driver.sv | 118 +++++++++++
 tb/tb_spart_driver.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/spart_pkg.sv
// Shared encodings, driver state enum and baud divisor helper for the SPART driver.
package spart_pkg;

  localparam logic [1:0] ADDR_BUF  = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  typedef enum logic [2:0] {CFG_LO, CFG_HI, IDLE, RD, WR, HOLD} drv_state_t;

  // round(clk_hz / (16 * baud)) - 1, baud = 4800 << sel
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
    int unsigned baud;
    int unsigned div;
    baud = 32'd4800 << sel;
    div  = (clk_hz + 8 * baud) / (16 * baud) - 1;
    return div[15:0];
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Processor-side SPART control bus: select, direction, address and status flags.
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (output iocs, iorw, ioaddr, input rda, tbr);
  modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_fifo.sv
// Synchronous byte FIFO; pointers wrap modulo DEPTH (power of two), count spans 0..DEPTH.
module spart_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spart_driver.sv
// SPART bus master: programs the baud divisor, then echoes received bytes through a FIFO.
// Optional SPART_DRIVER_UPCASE_EN folds ASCII lowercase to uppercase on the transmit path.
module spart_driver
  import spart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  br_cfg,
  spart_driver_if.master              bus,
  inout  wire  [7:0]                  databus,
  output logic                        cfg_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
);
  drv_state_t  state;
  logic [1:0]  cfg_q;
  logic [1:0]  sel_q;
  logic [7:0]  dout_q;
  logic [7:0]  head;
  logic [7:0]  tx_byte;
  logic [15:0] div_new;
  logic [15:0] div_sel;
  logic        full;
  logic        empty;

  // Low byte uses the live select, high byte the select captured with it, so a
  // change between the two writes is caught by the mismatch check in IDLE.
  assign div_new = baud_div(CLK_HZ, br_cfg);
  assign div_sel = baud_div(CLK_HZ, sel_q);

  assign databus = (bus.iocs && !bus.iorw) ? dout_q : 8'bz;

`ifdef SPART_DRIVER_UPCASE_EN
  assign tx_byte = (head >= 8'h61 && head <= 8'h7A) ? (head - 8'h20) : head;
`else
  assign tx_byte = head;
`endif

  spart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (state == RD),
    .pop   (state == WR),
    .din   (databus),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // Accesses are issued one cycle ahead; gating on !iocs keeps strobes apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_LO;
      bus.iocs   <= 1'b0;
      bus.iorw   <= 1'b1;
      bus.ioaddr <= ADDR_BUF;
      dout_q     <= 8'h00;
      cfg_done   <= 1'b0;
      cfg_q      <= 2'b00;
      sel_q      <= 2'b00;
    end else begin
      bus.iocs <= 1'b0;
      bus.iorw <= 1'b1;
      case (state)
        CFG_LO: if (!bus.iocs) begin
          bus.iocs   <= 1'b1;
          bus.iorw   <= 1'b0;
          bus.ioaddr <= ADDR_DBL;
          dout_q     <= div_new[7:0];
          sel_q      <= br_cfg;
          state      <= CFG_HI;
        end
        CFG_HI: if (!bus.iocs) begin
          bus.iocs   <= 1'b1;
          bus.iorw   <= 1'b0;
          bus.ioaddr <= ADDR_DBH;
          dout_q     <= div_sel[15:8];
          cfg_q      <= sel_q;
          state      <= IDLE;
        end
        IDLE: begin
          if (br_cfg != cfg_q) begin
            cfg_done <= 1'b0;
            state    <= CFG_LO;
          end else begin
            cfg_done <= 1'b1;
            if (!bus.iocs) begin
              if (bus.rda && !full) begin
                bus.iocs   <= 1'b1;
                bus.ioaddr <= ADDR_BUF;
                state      <= RD;
              end else if (bus.tbr && !empty) begin
                bus.iocs   <= 1'b1;
                bus.iorw   <= 1'b0;
                bus.ioaddr <= ADDR_BUF;
                dout_q     <= tx_byte;
                state      <= WR;
              end
            end
          end
        end
        RD, WR: state <= HOLD;
        HOLD: begin
          if (br_cfg != cfg_q) begin
            cfg_done <= 1'b0;
            state    <= CFG_LO;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= CFG_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_driver.sv
// Directed bench for spart_driver: model SPART plus an access scoreboard.
module tb_spart_driver;
  import spart_pkg::*;

  typedef struct {
    logic       rw;
    logic [1:0] addr;
    logic [7:0] dat;
  } acc_t;

  logic       clk;
  logic       rst;
  logic [1:0] br_cfg;
  logic       cfg_done;
  logic [2:0] fifo_cnt;
  logic [7:0] tb_byte;
  wire  [7:0] databus;

  spart_driver_if sif();

  spart_driver #(.CLK_HZ(50000000), .FIFO_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .br_cfg   (br_cfg),
    .bus      (sif),
    .databus  (databus),
    .cfg_done (cfg_done),
    .fifo_cnt (fifo_cnt)
  );

  assign databus = (sif.iocs && sif.iorw) ? tb_byte : 8'bz;

  int   total = 0;
  int   bad   = 0;
  acc_t exp_q[$];
  logic [7:0] rxq[$];
  logic prev_iocs = 1'b0;
  logic pop_pend  = 1'b0;
  int   max_cnt   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_acc(input logic rw, input logic [1:0] addr, input logic [7:0] dat);
    acc_t e;
    e.rw = rw; e.addr = addr; e.dat = dat;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (8) @(negedge clk);
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_cfg(input string name, input logic val);
    int n = 0;
    while (cfg_done !== val && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(cfg_done), int'(val));
  endtask

  // Monitor and model SPART share the falling edge: check first, then update model.
  always @(negedge clk) begin
    acc_t e;
    if (sif.iocs === 1'b1) begin
      chk("iocs_gap", int'(prev_iocs), 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_access", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("acc_rw", int'(sif.iorw), int'(e.rw));
        chk("acc_addr", int'(sif.ioaddr), int'(e.addr));
        chk("acc_data", int'(databus), int'(e.dat));
        if (e.addr == ADDR_DBL || e.addr == ADDR_DBH) chk("cfg_done_during_cfg", int'(cfg_done), 0);
      end
    end
    prev_iocs = sif.iocs;
    if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
    if (pop_pend && rxq.size() != 0) void'(rxq.pop_front());
    pop_pend = (sif.iocs === 1'b1) && (sif.iorw === 1'b1) && (sif.ioaddr == ADDR_BUF);
    sif.rda  = (rxq.size() != 0);
    tb_byte  = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  initial begin
    logic [7:0] up_exp;
    int n;
    rst     = 1'b1;
    br_cfg  = 2'b01;
    sif.tbr = 1'b0;
    sif.rda = 1'b0;
    tb_byte = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_iocs", int'(sif.iocs), 0);
    chk("rst_iorw", int'(sif.iorw), 1);
    chk("rst_ioaddr", int'(sif.ioaddr), 0);
    chk("rst_cfg_done", int'(cfg_done), 0);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);

    // Divisor for 9600 baud at 50 MHz is 0x0145.
    expect_acc(1'b0, ADDR_DBL, 8'h45);
    expect_acc(1'b0, ADDR_DBH, 8'h01);
    rst = 1'b0;
    wait_cfg("cfg_done_9600", 1'b1);
    wait_drain("drain_cfg_9600");

    // Single echo.
    max_cnt = 0;
    sif.tbr = 1'b1;
    rxq.push_back(8'h41);
    expect_acc(1'b1, ADDR_BUF, 8'h41);
    expect_acc(1'b0, ADDR_BUF, 8'h41);
    wait_drain("drain_echo1");
    chk("echo1_max_cnt", max_cnt, 1);
    chk("echo1_cnt_end", int'(fifo_cnt), 0);

    // Fill: fifth byte stays in the spart while the FIFO is full.
    sif.tbr = 1'b0;
    for (int i = 0; i < 5; i++) rxq.push_back(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) expect_acc(1'b1, ADDR_BUF, 8'(8'h10 + i));
    wait_drain("drain_fill");
    repeat (10) @(negedge clk);
    chk("full_cnt", int'(fifo_cnt), 4);
    chk("full_left_in_spart", rxq.size(), 1);
    // Read has priority as soon as the first pop frees a slot.
    expect_acc(1'b0, ADDR_BUF, 8'h10);
    expect_acc(1'b1, ADDR_BUF, 8'h14);
    for (int i = 1; i < 5; i++) expect_acc(1'b0, ADDR_BUF, 8'(8'h10 + i));
    sif.tbr = 1'b1;
    wait_drain("drain_full");
    chk("full_cnt_end", int'(fifo_cnt), 0);

    // Reconfigure to 38400 (0x0050) with two bytes queued.
    sif.tbr = 1'b0;
    rxq.push_back(8'h21);
    rxq.push_back(8'h22);
    expect_acc(1'b1, ADDR_BUF, 8'h21);
    expect_acc(1'b1, ADDR_BUF, 8'h22);
    wait_drain("drain_two");
    chk("two_cnt", int'(fifo_cnt), 2);
    expect_acc(1'b0, ADDR_DBL, 8'h50);
    expect_acc(1'b0, ADDR_DBH, 8'h00);
    br_cfg = 2'b11;
    wait_cfg("cfg_done_drop", 1'b0);
    wait_cfg("cfg_done_38400", 1'b1);
    wait_drain("drain_cfg_38400");
    chk("cnt_kept_over_cfg", int'(fifo_cnt), 2);
    expect_acc(1'b0, ADDR_BUF, 8'h21);
    expect_acc(1'b0, ADDR_BUF, 8'h22);
    sif.tbr = 1'b1;
    wait_drain("drain_after_cfg");
    chk("after_cfg_cnt", int'(fifo_cnt), 0);

    // Reset during a write cycle.
    sif.tbr = 1'b0;
    rxq.push_back(8'h33);
    expect_acc(1'b1, ADDR_BUF, 8'h33);
    wait_drain("drain_pre_rst");
    expect_acc(1'b0, ADDR_BUF, 8'h33);
    sif.tbr = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.iocs === 1'b1 && sif.iorw === 1'b0) && n < 50);
    chk("wr_seen_before_rst", int'(sif.iocs === 1'b1 && sif.iorw === 1'b0), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_iocs", int'(sif.iocs), 0);
    chk("midrst_iorw", int'(sif.iorw), 1);
    chk("midrst_fifo_cnt", int'(fifo_cnt), 0);
    chk("midrst_cfg_done", int'(cfg_done), 0);
    expect_acc(1'b0, ADDR_DBL, 8'h50);
    expect_acc(1'b0, ADDR_DBH, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    wait_cfg("cfg_done_after_rst", 1'b1);
    wait_drain("drain_after_rst");

    // Case folding path (0x7B is outside the lowercase range).
`ifdef SPART_DRIVER_UPCASE_EN
    up_exp = 8'h41;
`else
    up_exp = 8'h61;
`endif
    rxq.push_back(8'h61);
    rxq.push_back(8'h7B);
    expect_acc(1'b1, ADDR_BUF, 8'h61);
    expect_acc(1'b1, ADDR_BUF, 8'h7B);
    expect_acc(1'b0, ADDR_BUF, up_exp);
    expect_acc(1'b0, ADDR_BUF, 8'h7B);
    wait_drain("drain_upcase");
    chk("end_cnt", int'(fifo_cnt), 0);
    chk("end_spart_empty", rxq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
